// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// clk_period_meter: measures period/high time of an async signal in clk cycles,
// flags signal loss and period lock.                          Revision: 1.0
// ============================================================================
module clk_period_meter #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1000,
  parameter int LOCK_TOL = 1,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);

  localparam int               LCK_W      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   C_TOL      = (CNT_W + 1)'(LOCK_TOL);
  localparam logic [LCK_W-1:0] C_LOCK_CNT = LCK_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_MEASURE    = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2, r_dly;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_hcnt, w_hcnt_nxt;
  logic             r_high_phase, w_high_phase_nxt;
  logic [CNT_W-1:0] r_prev, w_prev_nxt;
  logic             r_have_prev, w_have_prev_nxt;
  logic [LCK_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic [CNT_W-1:0] r_high, w_high_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             r_locked, w_locked_nxt;

  logic             w_rise, w_fall;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W:0]   w_diff, w_abs;
  logic             w_stable;
  logic [LCK_W-1:0] w_lock_inc;

  assign w_rise     = r_sync2 & ~r_dly;
  assign w_fall     = ~r_sync2 & r_dly;
  assign w_cnt_inc  = r_cnt + 1'b1;
  // Extra bit keeps the sign of the period delta for the tolerance test.
  assign w_diff     = {1'b0, r_cnt} - {1'b0, r_prev};
  assign w_abs      = w_diff[CNT_W] ? -w_diff : w_diff;
  assign w_stable   = (w_abs <= C_TOL);
  assign w_lock_inc = (r_lock_cnt == C_LOCK_CNT) ? r_lock_cnt : r_lock_cnt + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_hcnt_nxt       = r_hcnt;
    w_high_phase_nxt = r_high_phase;
    w_prev_nxt       = r_prev;
    w_have_prev_nxt  = r_have_prev;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_period_nxt     = r_period;
    w_high_nxt       = r_high;
    w_valid_nxt      = 1'b0;
    w_timeout_nxt    = 1'b0;
    w_locked_nxt     = r_locked;

    if (!en) begin
      w_state_nxt      = S_IDLE;
      w_cnt_nxt        = '0;
      w_hcnt_nxt       = '0;
      w_high_phase_nxt = 1'b0;
      w_have_prev_nxt  = 1'b0;
      w_lock_cnt_nxt   = '0;
      w_locked_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt        = '0;
          w_hcnt_nxt       = '0;
          w_high_phase_nxt = 1'b0;
          w_have_prev_nxt  = 1'b0;
          w_state_nxt      = S_WAIT_FIRST;
        end
        S_WAIT_FIRST: begin
          if (w_rise) begin
            w_cnt_nxt        = CNT_W'(1);
            w_hcnt_nxt       = CNT_W'(1);
            w_high_phase_nxt = 1'b1;
            w_state_nxt      = S_MEASURE;
          end else if (w_cnt_inc == C_TIMEOUT) begin
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_MEASURE: begin
          if (w_rise) begin
            w_period_nxt     = r_cnt;
            w_high_nxt       = r_hcnt;
            w_valid_nxt      = 1'b1;
            w_prev_nxt       = r_cnt;
            w_have_prev_nxt  = 1'b1;
            w_cnt_nxt        = CNT_W'(1);
            w_hcnt_nxt       = CNT_W'(1);
            w_high_phase_nxt = 1'b1;
            if (r_have_prev) begin
              if (w_stable) begin
                w_lock_cnt_nxt = w_lock_inc;
                w_locked_nxt   = (w_lock_inc == C_LOCK_CNT);
              end else begin
                w_lock_cnt_nxt = '0;
                w_locked_nxt   = 1'b0;
              end
            end
          end else if (w_cnt_inc == C_TIMEOUT) begin
            w_timeout_nxt    = 1'b1;
            w_locked_nxt     = 1'b0;
            w_lock_cnt_nxt   = '0;
            w_have_prev_nxt  = 1'b0;
            w_cnt_nxt        = '0;
            w_hcnt_nxt       = '0;
            w_high_phase_nxt = 1'b0;
            w_state_nxt      = S_WAIT_FIRST;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            // The fall cycle itself is not counted as high time.
            if (r_high_phase && !w_fall) w_hcnt_nxt = r_hcnt + 1'b1;
            if (w_fall) w_high_phase_nxt = 1'b0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_dly        <= 1'b0;
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_high_phase <= 1'b0;
      r_prev       <= '0;
      r_have_prev  <= 1'b0;
      r_lock_cnt   <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_sync1      <= sig_in;
      r_sync2      <= r_sync1;
      r_dly        <= r_sync2;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_high_phase <= w_high_phase_nxt;
      r_prev       <= w_prev_nxt;
      r_have_prev  <= w_have_prev_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_period     <= w_period_nxt;
      r_high       <= w_high_nxt;
      r_valid      <= w_valid_nxt;
      r_timeout    <= w_timeout_nxt;
      r_locked     <= w_locked_nxt;
    end
  end

  assign period_o   = r_period;
  assign high_o     = r_high;
  assign meas_valid = r_valid;
  assign timeout    = r_timeout;
  assign locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// tb_clk_period_meter: scoreboard bench driving directed sig_in waveforms.
// Revision: 1.0
// ============================================================================
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst_n, en, sig_in;
  logic [15:0] period_o, high_o;
  logic        meas_valid, timeout, locked;

  always #5 clk = ~clk;

  clk_period_meter #(
    .CNT_W(16), .TIMEOUT(1000), .LOCK_TOL(1), .LOCK_CNT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .period_o(period_o), .high_o(high_o),
    .meas_valid(meas_valid), .timeout(timeout), .locked(locked)
  );

  typedef struct {
    logic [15:0] p;
    logic [15:0] h;
    logic        lk;
  } exp_t;

  exp_t exp_q[$];
  int   to_stamp[$];
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  int   m_tests = 0, m_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per meas_valid pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (meas_valid) begin
      m_tests++;
      if (exp_q.size() == 0) begin
        m_fail++;
        $display("FAIL unexpected_valid: got period=%0d high=%0d, required no valid", period_o, high_o);
      end else begin
        e = exp_q.pop_front();
        if (period_o !== e.p || high_o !== e.h || locked !== e.lk) begin
          m_fail++;
          $display("FAIL meas: got period=%0d high=%0d locked=%0b, required period=%0d high=%0d locked=%0b",
                   period_o, high_o, locked, e.p, e.h, e.lk);
        end
      end
    end
    if (timeout) to_stamp.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int p, input int h, input logic lk);
    exp_t e;
    e.p  = 16'(p);
    e.h  = 16'(h);
    e.lk = lk;
    exp_q.push_back(e);
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1; tick(h);
      sig_in = 1'b0; tick(l);
    end
  endtask

  task automatic start_sec();
    rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
    tick(2);
    rst_n = 1'b1; en = 1'b1;
    tick(2);
  endtask

  task automatic drained(input string name);
    tick(6);
    check(name, exp_q.size(), 0);
  endtask

  int base;

  initial begin
    rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
    tick(3);
    check("rst_period", period_o, 0);
    check("rst_high", high_o, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_locked", locked, 0);

    // Square wave 5/5: lock on the third measurement.
    start_sec();
    push(10, 5, 0); push(10, 5, 0); push(10, 5, 1); push(10, 5, 1); push(10, 5, 1);
    wave(5, 5, 6);
    drained("sq_drain");
    check("sq_locked", locked, 1);

    // 3/7 then 5/15: lock drops on the first 20 and returns two periods later.
    start_sec();
    push(10, 3, 0); push(10, 3, 0); push(10, 3, 1); push(10, 3, 1);
    push(20, 5, 0); push(20, 5, 0); push(20, 5, 1);
    wave(3, 7, 4);
    wave(5, 15, 4);
    drained("duty_drain");
    check("duty_locked", locked, 1);

    // Stuck low: timeouts every 1000 cycles, never a measurement.
    start_sec();
    base = to_stamp.size();
    tick(3500);
    check("to_count", to_stamp.size() - base, 3);
    if (to_stamp.size() - base >= 3) begin
      check("to_gap1", to_stamp[base+1] - to_stamp[base], 1000);
      check("to_gap2", to_stamp[base+2] - to_stamp[base+1], 1000);
    end
    check("to_locked", locked, 0);
    check("to_period", period_o, 0);

    // Alternating 10/11 is within tolerance.
    start_sec();
    push(10, 5, 0); push(11, 5, 0); push(10, 5, 1); push(11, 5, 1);
    wave(5, 5, 1); wave(5, 6, 1); wave(5, 5, 1); wave(5, 6, 1); wave(5, 5, 1);
    drained("alt11_drain");
    check("alt11_locked", locked, 1);

    // Alternating 10/12 never locks.
    start_sec();
    push(10, 5, 0); push(12, 5, 0); push(10, 5, 0); push(12, 5, 0);
    wave(5, 5, 1); wave(5, 7, 1); wave(5, 5, 1); wave(5, 7, 1); wave(5, 5, 1);
    drained("alt12_drain");
    check("alt12_locked", locked, 0);

    // Reset in the middle of a period.
    start_sec();
    push(10, 5, 0); push(10, 5, 0); push(10, 5, 1);
    wave(5, 5, 3);
    sig_in = 1'b1; tick(5);
    sig_in = 1'b0; tick(2);
    check("mid_pre_locked", locked, 1);
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1;
    check("mid_period", period_o, 0);
    check("mid_high", high_o, 0);
    check("mid_locked", locked, 0);
    check("mid_valid", meas_valid, 0);
    tick(3);
    push(10, 5, 0); push(10, 5, 0);
    wave(5, 5, 3);
    drained("mid_drain");

    // Enable drop mid-period: lock lost, results retained, one rise consumed.
    start_sec();
    push(10, 5, 0); push(10, 5, 0); push(10, 5, 1); push(10, 5, 1);
    wave(5, 5, 4);
    sig_in = 1'b1; tick(4);
    check("en_pre_locked", locked, 1);
    en = 1'b0; tick(1);
    sig_in = 1'b0; tick(5);
    check("en_locked", locked, 0);
    check("en_period", period_o, 10);
    check("en_high", high_o, 5);
    en = 1'b1; tick(3);
    push(10, 5, 0); push(10, 5, 0);
    wave(5, 5, 3);
    drained("en_drain");

    check("to_total", to_stamp.size(), 3);

    n_tests += m_tests;
    n_fail  += m_fail;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
